pw_multi_pattern_matcher: RTL and testbench

PW_MULTI_PATTERN_MATCHER -- requirements
Module: pw_multi_pattern_matcher

---
 rtl/pw_multi_pattern_matcher.sv | 171 +++++++++++++++++
 tb/tb_pw_multi_pattern_matcher.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_multi_pattern_matcher.sv
// Multi-channel masked byte-pattern matcher over a captured byte stream.
// Each channel compares its pattern against the newest bytes and pulses on a hit; trigger, id, count and done summarise the hits.
module pw_multi_pattern_matcher #(
   parameter int pCHANNELS      = 4,
   parameter int pPATTERN_BYTES = 16,
   parameter int pCOUNT_WIDTH   = 16
) (
   input  logic                                    fe_clk,
   input  logic                                    reset_n,
   input  logic                                    I_arm,
   input  logic                                    I_continuous,
   input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0]   I_pattern,
   input  logic [pCHANNELS*pPATTERN_BYTES*8-1:0]   I_mask,
   input  logic [pCHANNELS*8-1:0]                  I_pattern_len,
   input  logic [7:0]                              I_fe_data,
   input  logic                                    I_fe_data_valid,
   output logic [pCHANNELS-1:0]                    O_match,
   output logic                                    O_trigger,
   output logic [2:0]                              O_match_id,
   output logic [pCOUNT_WIDTH-1:0]                 O_match_count,
   output logic                                    O_done
);

   localparam int FILL_W = $clog2(pPATTERN_BYTES + 1);
   // The oldest history byte never reaches the comparison window, so it is not stored.
   localparam int HIST_DEPTH = (pPATTERN_BYTES > 1) ? pPATTERN_BYTES - 1 : 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(pPATTERN_BYTES);

   function automatic logic [2:0] lowest_idx(input logic [pCHANNELS-1:0] vec);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = pCHANNELS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [7:0]              hist_r [HIST_DEPTH];
   logic [7:0]              win_s  [pPATTERN_BYTES];
   logic [FILL_W-1:0]       fill_r;
   logic                    arm_d_r;
   logic [pCHANNELS-1:0]    match_r;
   logic                    trigger_r;
   logic [2:0]              id_r;
   logic [pCOUNT_WIDTH-1:0] count_r;
   logic                    done_r;

   logic                    accept_s;
   logic [pCHANNELS-1:0]    hit_s;
   logic                    arm_rise_s;
   logic                    done_eff_s;
   logic [pCOUNT_WIDTH-1:0] count_base_s;
   logic [2:0]              id_base_s;
   logic [pCHANNELS-1:0]    match_s;
   logic                    trigger_s;
   logic [2:0]              id_next_s;
   logic [pCOUNT_WIDTH-1:0] count_next_s;
   logic                    done_next_s;

   assign accept_s = I_arm & I_fe_data_valid;

   // Comparison window: incoming byte followed by the newest history bytes.
   always_comb begin
      win_s[0] = I_fe_data;
      for (int j = 1; j < pPATTERN_BYTES; j++) begin
         win_s[j] = hist_r[j-1];
      end
   end

   // Per-channel masked compare; pattern byte k lines up with the byte L-1-k beats back.
   always_comb begin
      hit_s = '0;
      for (int c = 0; c < pCHANNELS; c++) begin
         int  len_i;
         logic ok;
         len_i = int'(I_pattern_len[c*8 +: 8]);
         ok = accept_s && (len_i >= 1) && (len_i <= pPATTERN_BYTES) &&
              ((int'(fill_r) + 1) >= len_i);
         for (int k = 0; k < pPATTERN_BYTES; k++) begin
            for (int j = 0; j < pPATTERN_BYTES; j++) begin
               if ((k < len_i) && ((k + j + 1) == len_i) &&
                   (((I_pattern[(c*pPATTERN_BYTES+k)*8 +: 8] ^ win_s[j]) &
                     I_mask[(c*pPATTERN_BYTES+k)*8 +: 8]) != 8'h00)) begin
                  ok = 1'b0;
               end else begin
                  ok = ok;
               end
            end
         end
         hit_s[c] = ok;
      end
   end

   // Arm-edge clearing, one-shot suppression and next values of the status outputs.
   always_comb begin
      arm_rise_s   = I_arm & ~arm_d_r;
      done_eff_s   = arm_rise_s ? 1'b0 : done_r;
      count_base_s = arm_rise_s ? '0 : count_r;
      id_base_s    = arm_rise_s ? 3'd0 : id_r;
      match_s      = done_eff_s ? '0 : hit_s;
      trigger_s    = |match_s;
      id_next_s    = id_base_s;
      count_next_s = count_base_s;
      done_next_s  = done_eff_s;
      if (trigger_s) begin
         id_next_s   = lowest_idx(match_s);
         done_next_s = done_eff_s | ~I_continuous;
         if (count_base_s != {pCOUNT_WIDTH{1'b1}}) begin
            count_next_s = count_base_s + pCOUNT_WIDTH'(1);
         end else begin
            count_next_s = count_base_s;
         end
      end else begin
         id_next_s = id_base_s;
      end
   end

   // Byte history and fill level.
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < HIST_DEPTH; j++) begin
            hist_r[j] <= 8'h00;
         end
         fill_r <= '0;
      end else begin
         if (accept_s) begin
            hist_r[0] <= I_fe_data;
            for (int j = 1; j < HIST_DEPTH; j++) begin
               hist_r[j] <= hist_r[j-1];
            end
         end
         if (!I_arm) begin
            fill_r <= '0;
         end else if (accept_s && (fill_r != FILL_MAX)) begin
            fill_r <= fill_r + FILL_W'(1);
         end else begin
            fill_r <= fill_r;
         end
      end
   end

   // Registered match, trigger and status outputs.
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_d_r   <= 1'b0;
         match_r   <= '0;
         trigger_r <= 1'b0;
         id_r      <= 3'd0;
         count_r   <= '0;
         done_r    <= 1'b0;
      end else begin
         arm_d_r   <= I_arm;
         match_r   <= match_s;
         trigger_r <= trigger_s;
         id_r      <= id_next_s;
         count_r   <= count_next_s;
         done_r    <= done_next_s;
      end
   end

   assign O_match       = match_r;
   assign O_trigger     = trigger_r;
   assign O_match_id    = id_r;
   assign O_match_count = count_r;
   assign O_done        = done_r;

endmodule

// File: tb/tb_pw_multi_pattern_matcher.sv
// Scoreboard bench: a queue-based stream model predicts every cycle's outputs; a negedge monitor compares.
module tb_pw_multi_pattern_matcher;

   localparam int C  = 4;
   localparam int P  = 8;
   localparam int CW = 4;

   logic              fe_clk = 1'b0;
   logic              reset_n;
   logic              I_arm;
   logic              I_continuous;
   logic [C*P*8-1:0]  I_pattern;
   logic [C*P*8-1:0]  I_mask;
   logic [C*8-1:0]    I_pattern_len;
   logic [7:0]        I_fe_data;
   logic              I_fe_data_valid;
   logic [C-1:0]      O_match;
   logic              O_trigger;
   logic [2:0]        O_match_id;
   logic [CW-1:0]     O_match_count;
   logic              O_done;

   always #5 fe_clk = ~fe_clk;

   pw_multi_pattern_matcher #(
      .pCHANNELS(C), .pPATTERN_BYTES(P), .pCOUNT_WIDTH(CW)
   ) dut (
      .fe_clk(fe_clk), .reset_n(reset_n), .I_arm(I_arm), .I_continuous(I_continuous),
      .I_pattern(I_pattern), .I_mask(I_mask), .I_pattern_len(I_pattern_len),
      .I_fe_data(I_fe_data), .I_fe_data_valid(I_fe_data_valid),
      .O_match(O_match), .O_trigger(O_trigger), .O_match_id(O_match_id),
      .O_match_count(O_match_count), .O_done(O_done)
   );

   typedef struct {
      logic [C-1:0]  m;
      logic          t;
      logic [2:0]    id;
      logic [CW-1:0] cnt;
      logic          done;
      int            cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] bytes_q[$];   // accepted bytes since arm/reset, newest at the back, at most P
   int         m_count, m_id, m_done, m_armd;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   // Reference: predict the outputs after the clock edge that just sampled the inputs.
   function automatic void model_step();
      exp_t e;
      int   hits, rise, done_eff, cnt_base, id_base;
      cyc++;
      e.cyc = cyc;
      if (!reset_n) begin
         bytes_q.delete();
         m_count = 0; m_id = 0; m_done = 0; m_armd = 0;
         hits = 0;
      end else begin
         rise     = (I_arm && !m_armd) ? 1 : 0;
         done_eff = rise ? 0 : m_done;
         cnt_base = rise ? 0 : m_count;
         id_base  = rise ? 0 : m_id;
         hits = 0;
         if (I_arm && I_fe_data_valid) begin
            for (int c = 0; c < C; c++) begin
               int L;
               bit ok;
               L  = int'(I_pattern_len[c*8 +: 8]);
               ok = (L >= 1) && (L <= P) && (bytes_q.size() + 1 >= L);
               if (ok) begin
                  for (int k = 0; k < L; k++) begin
                     int back;
                     logic [7:0] b;
                     back = L - 1 - k;
                     b = (back == 0) ? I_fe_data : bytes_q[bytes_q.size() - back];
                     if (((I_pattern[(c*P+k)*8 +: 8] ^ b) & I_mask[(c*P+k)*8 +: 8]) != 8'h00)
                        ok = 0;
                  end
               end
               if (ok) hits |= (1 << c);
            end
         end
         if (done_eff != 0) hits = 0;
         if (hits != 0) begin
            for (int c = C - 1; c >= 0; c--) if (hits[c]) id_base = c;
            cnt_base = (cnt_base == (1 << CW) - 1) ? cnt_base : cnt_base + 1;
            done_eff = (done_eff != 0 || !I_continuous) ? 1 : 0;
         end
         m_count = cnt_base; m_id = id_base; m_done = done_eff;
         if (!I_arm) bytes_q.delete();
         else if (I_fe_data_valid) begin
            bytes_q.push_back(I_fe_data);
            if (bytes_q.size() > P) void'(bytes_q.pop_front());
         end
         m_armd = I_arm ? 1 : 0;
      end
      e.m    = hits[C-1:0];
      e.t    = (hits != 0);
      e.id   = m_id[2:0];
      e.cnt  = m_count[CW-1:0];
      e.done = m_done[0];
      exp_q.push_back(e);
   endfunction

   // Monitor: compare every predicted cycle against the DUT outputs.
   always @(negedge fe_clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (O_match !== e.m || O_trigger !== e.t || O_match_id !== e.id ||
             O_match_count !== e.cnt || O_done !== e.done) begin
            errors++;
            $display("FAIL outputs cyc=%0d got match=%b trig=%b id=%0d cnt=%0d done=%b exp match=%b trig=%b id=%0d cnt=%0d done=%b",
                     e.cyc, O_match, O_trigger, O_match_id, O_match_count, O_done,
                     e.m, e.t, e.id, e.cnt, e.done);
         end
      end
   end

   task automatic beat(input logic v, input logic [7:0] d);
      I_fe_data_valid = v;
      I_fe_data       = d;
      @(posedge fe_clk);
      #1;
      model_step();
      @(negedge fe_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 8'h00);
   endtask

   task automatic clear_cfg();
      I_pattern     = '0;
      I_mask        = '1;
      I_pattern_len = '0;
   endtask

   task automatic set_byte(input int c, input int k, input logic [7:0] b, input logic [7:0] m);
      I_pattern[(c*P+k)*8 +: 8] = b;
      I_mask[(c*P+k)*8 +: 8]    = m;
   endtask

   task automatic set_len(input int c, input logic [7:0] l);
      I_pattern_len[c*8 +: 8] = l;
   endtask

   task automatic set_123456(input int c);
      set_byte(c, 0, 8'h12, 8'hFF);
      set_byte(c, 1, 8'h34, 8'hFF);
      set_byte(c, 2, 8'h56, 8'hFF);
      set_len(c, 8'd3);
   endtask

   initial begin
      reset_n = 1'b0; I_arm = 1'b0; I_continuous = 1'b1;
      I_fe_data = 8'h00; I_fe_data_valid = 1'b0;
      clear_cfg();
      @(negedge fe_clk);
      #1;
      idle(3);
      reset_n = 1'b1;
      idle(2);

      // Three-byte pattern on ch0, continuous mode.
      set_123456(0);
      I_arm = 1'b1;
      idle(1);
      beat(1'b1, 8'h12); beat(1'b1, 8'h34); beat(1'b1, 8'h56);
      idle(2);

      // Overlapping AA AA on ch1 with idle gaps.
      clear_cfg();
      set_byte(1, 0, 8'hAA, 8'hFF); set_byte(1, 1, 8'hAA, 8'hFF); set_len(1, 8'd2);
      beat(1'b1, 8'hAA); idle(1); beat(1'b1, 8'hAA); idle(2); beat(1'b1, 8'hAA); idle(2);

      // Two channels hit on the same beat.
      clear_cfg();
      for (int c = 0; c <= 2; c += 2) begin
         set_byte(c, 0, 8'h77, 8'hFF); set_byte(c, 1, 8'h88, 8'hFF); set_len(c, 8'd2);
      end
      beat(1'b1, 8'h77); beat(1'b1, 8'h88); idle(2);

      // One-shot mode, then re-arm.
      clear_cfg();
      set_byte(0, 0, 8'h3C, 8'hFF); set_len(0, 8'd1);
      I_continuous = 1'b0;
      I_arm = 1'b0; idle(2); I_arm = 1'b1; idle(1);
      for (int i = 0; i < 3; i++) begin beat(1'b1, 8'h3C); idle(1); end
      I_arm = 1'b0; idle(2); I_arm = 1'b1; idle(1);
      beat(1'b1, 8'h3C); idle(2);
      I_continuous = 1'b1;

      // Masked byte plus disabled and over-long lengths.
      clear_cfg();
      set_byte(0, 0, 8'h05, 8'h0F); set_len(0, 8'd1);
      set_byte(1, 0, 8'hF5, 8'hFF); set_len(1, 8'd0);
      for (int k = 0; k < P; k++) begin
         set_byte(2, k, 8'hF5, 8'hFF);
         set_byte(3, k, 8'hF5, 8'h00);
      end
      set_len(2, 8'd9); set_len(3, 8'd200);
      beat(1'b1, 8'hF5); beat(1'b1, 8'hF4);
      for (int i = 0; i < 10; i++) beat(1'b1, 8'hF5);
      idle(2);

      // Reset in the middle of a pattern.
      clear_cfg();
      set_123456(0);
      beat(1'b1, 8'h12); beat(1'b1, 8'h34);
      reset_n = 1'b0; idle(2); reset_n = 1'b1;
      beat(1'b1, 8'h56); idle(1);
      beat(1'b1, 8'h12); beat(1'b1, 8'h34); beat(1'b1, 8'h56); idle(2);

      // Counter saturation with an always-matching channel.
      clear_cfg();
      set_byte(0, 0, 8'h00, 8'h00); set_len(0, 8'd1);
      for (int i = 0; i < 20; i++) beat(1'b1, 8'($urandom));
      idle(2);

      // Randomised configurations and stream over a two-symbol alphabet.
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) begin
            for (int c = 0; c < C; c++) begin
               int r;
               set_len(c, 8'($urandom_range(0, 10)));
               for (int k = 0; k < P; k++) begin
                  r = $urandom_range(0, 9);
                  set_byte(c, k, 8'hA0 | 8'($urandom_range(0, 1)),
                           (r < 7) ? 8'hFF : ((r < 9) ? 8'h00 : 8'($urandom)));
               end
            end
            I_continuous = ($urandom_range(0, 2) != 0);
         end
         if ($urandom_range(0, 49) == 0) I_arm = ~I_arm;
         if ($urandom_range(0, 99) == 0) I_continuous = ~I_continuous;
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 1'b0; idle(1); reset_n = 1'b1;
         end
         beat($urandom_range(0, 9) < 7, 8'hA0 | 8'($urandom_range(0, 1)));
      end
      idle(3);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge fe_clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
